hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS pipeline. Drives the write-enable and flush controls of the PC, the IF/ID register and the ID/EX register. Resolves load-use stalls, taken-branch flushes and multi-cycle mult/div holds, and keeps saturating stall and flush performance counters. Sits beside the ID stage and takes register fields from the ID instruction and status from EX.

## Interface
- MULDIV_CYCLES, 4: total EX cycles of a mult/div instruction; must be ≥ 1.
- CNT_W, 16: width of the performance counters.

- Clk  in  1  pipeline clock; all state changes on posedge.
- Rst_n  in  1  synchronous, active-low reset.
- ID_Rs  in  5  rs field of the ID instruction.
- ID_Rt  in  5  rt field of the ID instruction.
- ID_UsesRt  in  1  ID instruction reads rt as a source.
- ID_MulDiv  in  1  ID instruction is mult/multu/div/divu.
- EX_MemRead  in  1  EX instruction is a load.
- EX_WriteReg  in  5  destination register of the EX instruction.
- EX_BranchTaken  in  1  branch or jump in EX resolved taken.
- PCWrite  out  1  PC load enable.
- IF_ID_Write  out  1  IF/ID load enable.
- IF_ID_Flush  out  1  IF/ID loads zero (nop) on the next edge.
- ID_EX_Bubble  out  1  ID/EX loads zeroed control (bubble).
- EX_Hold  out  1  ID/EX holds; EX/MEM takes a bubble.
- Busy  out  1  mult/div wait in progress.
- StallCount  out  CNT_W  load-use and mult/div stall cycles, saturating.
- FlushCount  out  CNT_W  taken-branch flushes, saturating.

## Operation
- States:
  - RUN: normal operation.
  - MDWAIT: mult/div occupies EX. Down-counter md_cnt, width $clog2(MULDIV_CYCLES+1).
- Control outputs are Mealy (combinational from state and inputs). Counters and Busy are registered.
- Load-use hazard (LU): EX_MemRead && EX_WriteReg != 0 && (EX_WriteReg == ID_Rs || (ID_UsesRt && EX_WriteReg == ID_Rt)).
- RUN, priority order:
  1. EX_BranchTaken: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Bubble=1. FlushCount+1. LU and ID_MulDiv are ignored.
  2. LU: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1. StallCount+1.
  3. ID_MulDiv: normal advance (all writes 1, no flush or bubble). If MULDIV_CYCLES > 1, go to MDWAIT with md_cnt = MULDIV_CYCLES-1.
  4. Otherwise: PCWrite=1, IF_ID_Write=1, all other controls 0.
- MDWAIT outputs: PCWrite=0, IF_ID_Write=0, EX_Hold=1, Busy=1, IF_ID_Flush=0, ID_EX_Bubble=0. StallCount+1 each cycle.
- MDWAIT transitions: md_cnt decrements each cycle. Leaving the state at md_cnt==1 returns to RUN.
- MDWAIT ignores EX_BranchTaken, EX_MemRead and ID_MulDiv, since a mult/div instruction occupies EX.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset (Rst_n=0 at the edge): state RUN, md_cnt=0, Busy=0, StallCount=0, FlushCount=0.
- While Rst_n=0, combinational outputs are forced: PCWrite=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1, EX_Hold=0.
- Reset asserted during MDWAIT abandons the wait; RUN follows on the next edge.

## Timing
- Control outputs respond in the same cycle as their inputs, with zero latency, and are consumed at the next posedge.
- A load-use stall lasts exactly 1 cycle. After the bubble the load has moved to MEM, so LU does not retrigger.
- A mult/div instruction gives MULDIV_CYCLES-1 hold cycles after its advance into EX.
- Busy rises on the edge that enters MDWAIT and falls on the edge that leaves it.
- A branch flush costs 2 slots: the IF/ID instruction and the ID/EX instruction.
- Counter updates are visible 1 cycle after the qualifying cycle.

## Structure
- Shared package pipe_pkg holds:
  - state enum {RUN, MDWAIT};
  - REG_ZERO = 5'd0;
  - NOP_INSTR = 32'h0000_0000.
- Sub-module sat_counter (parameter W; ports inc, clear) is used twice for StallCount and FlushCount.
- All other logic is flat in hazard_ctrl.

## Test plan
- Reset: Rst_n=0 for 2 cycles, then 1 → during reset IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=0. After release, all counters are 0 and PCWrite=1.
- Load-use: EX_MemRead=1, EX_WriteReg=8, ID_Rs=8 → PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1 for 1 cycle, and StallCount=1. Repeat with EX_WriteReg=0 → no stall.
- rt gating: EX_WriteReg=9, ID_Rt=9 → stall only when ID_UsesRt=1.
- Branch versus load-use: EX_BranchTaken=1 together with an LU condition → IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1. FlushCount=1 and StallCount unchanged.
- Mult/div with MULDIV_CYCLES=4: ID_MulDiv=1 → 1 advance cycle, then 3 cycles with EX_Hold=1 and Busy=1. EX_BranchTaken=1 pulsed mid-wait is ignored, and StallCount=3.
- Reset and saturation:
  - Rst_n=0 during the 2nd MDWAIT cycle → Busy=0 and RUN after release.
  - With CNT_W=2, 5 load-use stalls → StallCount=3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the 5-stage core.
// Holds the hazard FSM state type and common constants.
package pipe_pkg;

  typedef enum logic {
    RUN,
    MDWAIT
  } state_t;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for pipeline performance events.
// Synchronous clear wins over increment; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // count qualifying cycles, stick at the maximum value
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller beside the ID stage.
// Load-use stalls, branch flushes, mult/div holds, perf counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_MulDiv,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_WriteReg,
  input  logic             EX_BranchTaken,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             EX_Hold,
  output logic             Busy,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int MD_W = $clog2(MULDIV_CYCLES + 1);
  localparam logic [MD_W-1:0] MD_INIT =
    MD_W'(MULDIV_CYCLES - 1);
  localparam bit MD_WAIT = (MULDIV_CYCLES > 1);

  state_t          state;
  state_t          state_nx;
  logic [MD_W-1:0] md_cnt;
  logic [MD_W-1:0] md_cnt_nx;
  logic            lu;
  logic            stall_inc;
  logic            flush_inc;

  assign lu = EX_MemRead
    && (EX_WriteReg != REG_ZERO)
    && ((EX_WriteReg == ID_Rs)
      || (ID_UsesRt && (EX_WriteReg == ID_Rt)));

  // state, wait counter and registered busy flag
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state  <= RUN;
      md_cnt <= '0;
      Busy   <= 1'b0;
    end else begin
      state  <= state_nx;
      md_cnt <= md_cnt_nx;
      Busy   <= (state_nx == MDWAIT);
    end
  end

  // Mealy pipeline controls and next-state selection
  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    EX_Hold      = 1'b0;
    state_nx     = state;
    md_cnt_nx    = md_cnt;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    if (!Rst_n) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
      state_nx     = RUN;
      md_cnt_nx    = '0;
    end else begin
      unique case (state)
        RUN: begin
          if (EX_BranchTaken) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
            flush_inc    = 1'b1;
          end else if (lu) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            stall_inc    = 1'b1;
          end else if (ID_MulDiv && MD_WAIT) begin
            state_nx  = MDWAIT;
            md_cnt_nx = MD_INIT;
          end
        end
        MDWAIT: begin
          PCWrite     = 1'b0;
          IF_ID_Write = 1'b0;
          EX_Hold     = 1'b1;
          stall_inc   = 1'b1;
          md_cnt_nx   = md_cnt - MD_W'(1);
          if (md_cnt <= MD_W'(1)) begin
            state_nx  = RUN;
            md_cnt_nx = '0;
          end
        end
        default: begin
          state_nx  = RUN;
          md_cnt_nx = '0;
        end
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (Clk),
    .clear(!Rst_n),
    .inc  (stall_inc),
    .count(StallCount)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk  (Clk),
    .clear(!Rst_n),
    .inc  (flush_inc),
    .count(FlushCount)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl.
// Directed vectors push expectations; a negedge monitor checks.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        uses_rt;
  logic        muldiv;
  logic        memrd;
  logic [4:0]  wreg;
  logic        br;

  logic        pcw;
  logic        ifw;
  logic        ifl;
  logic        bub;
  logic        hold;
  logic        busy;
  logic [15:0] scnt;
  logic [15:0] fcnt;

  logic        pcw2;
  logic        ifw2;
  logic        ifl2;
  logic        bub2;
  logic        hold2;
  logic        busy2;
  logic [1:0]  scnt2;
  logic [1:0]  fcnt2;

  typedef struct packed {
    logic        pc;
    logic        w;
    logic        fl;
    logic        bb;
    logic        h;
    logic        bz;
    logic [15:0] s;
    logic [15:0] f;
    logic [1:0]  s2;
  } exp_t;

  exp_t q[$];
  int   n_cmp;
  int   n_bad;
  int   vnum;

  hazard_ctrl #(
    .MULDIV_CYCLES(4),
    .CNT_W(16)
  ) dut (
    .Clk           (clk),
    .Rst_n         (rst_n),
    .ID_Rs         (rs),
    .ID_Rt         (rt),
    .ID_UsesRt     (uses_rt),
    .ID_MulDiv     (muldiv),
    .EX_MemRead    (memrd),
    .EX_WriteReg   (wreg),
    .EX_BranchTaken(br),
    .PCWrite       (pcw),
    .IF_ID_Write   (ifw),
    .IF_ID_Flush   (ifl),
    .ID_EX_Bubble  (bub),
    .EX_Hold       (hold),
    .Busy          (busy),
    .StallCount    (scnt),
    .FlushCount    (fcnt)
  );

  hazard_ctrl #(
    .MULDIV_CYCLES(4),
    .CNT_W(2)
  ) dut2 (
    .Clk           (clk),
    .Rst_n         (rst_n),
    .ID_Rs         (rs),
    .ID_Rt         (rt),
    .ID_UsesRt     (uses_rt),
    .ID_MulDiv     (muldiv),
    .EX_MemRead    (memrd),
    .EX_WriteReg   (wreg),
    .EX_BranchTaken(br),
    .PCWrite       (pcw2),
    .IF_ID_Write   (ifw2),
    .IF_ID_Flush   (ifl2),
    .ID_EX_Bubble  (bub2),
    .EX_Hold       (hold2),
    .Busy          (busy2),
    .StallCount    (scnt2),
    .FlushCount    (fcnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(
    input int pc, input int w, input int fl,
    input int bb, input int h, input int bz,
    input int s, input int f, input int s2
  );
    exp_t e;
    e.pc = pc[0];
    e.w  = w[0];
    e.fl = fl[0];
    e.bb = bb[0];
    e.h  = h[0];
    e.bz = bz[0];
    e.s  = s[15:0];
    e.f  = f[15:0];
    e.s2 = s2[1:0];
    return e;
  endfunction

  task automatic step(
    input int r, input int a, input int b,
    input int u, input int m, input int ld,
    input int d, input int t, input exp_t e
  );
    rst_n   = r[0];
    rs      = a[4:0];
    rt      = b[4:0];
    uses_rt = u[0];
    muldiv  = m[0];
    memrd   = ld[0];
    wreg    = d[4:0];
    br      = t[0];
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // monitor: pop one expectation per cycle and compare
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = q.pop_front();
      a.pc = pcw;
      a.w  = ifw;
      a.fl = ifl;
      a.bb = bub;
      a.h  = hold;
      a.bz = busy;
      a.s  = scnt;
      a.f  = fcnt;
      a.s2 = scnt2;
      vnum++;
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL vec%0d: got pc=%b w=%b fl=%b bb=%b h=%b bz=%b s=%0d f=%0d s2=%0d want pc=%b w=%b fl=%b bb=%b h=%b bz=%b s=%0d f=%0d s2=%0d",
          vnum, a.pc, a.w, a.fl, a.bb, a.h, a.bz,
          a.s, a.f, a.s2, e.pc, e.w, e.fl, e.bb,
          e.h, e.bz, e.s, e.f, e.s2);
      end
    end
  end

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    vnum    = 0;
    rst_n   = 1'b0;
    rs      = 5'd1;
    rt      = 5'd2;
    uses_rt = 1'b0;
    muldiv  = 1'b0;
    memrd   = 1'b0;
    wreg    = 5'd0;
    br      = 1'b0;
    @(posedge clk);
    #1;
    // reset held: forced controls, cleared state
    step(0, 1, 2, 0, 0, 0, 0, 0, mk(0,0,1,1,0,0,0,0,0));
    step(0, 1, 2, 0, 0, 0, 0, 0, mk(0,0,1,1,0,0,0,0,0));
    step(1, 1, 2, 0, 0, 0, 0, 0, mk(1,1,0,0,0,0,0,0,0));
    // load-use on rs, single-cycle stall
    step(1, 8, 2, 0, 0, 1, 8, 0, mk(0,0,0,1,0,0,0,0,0));
    step(1, 1, 2, 0, 0, 0, 0, 0, mk(1,1,0,0,0,0,1,0,1));
    // load to r0 never stalls
    step(1, 0, 2, 0, 0, 1, 0, 0, mk(1,1,0,0,0,0,1,0,1));
    // rt match gated by ID_UsesRt
    step(1, 1, 9, 0, 0, 1, 9, 0, mk(1,1,0,0,0,0,1,0,1));
    step(1, 1, 9, 1, 0, 1, 9, 0, mk(0,0,0,1,0,0,1,0,1));
    step(1, 1, 2, 0, 0, 0, 0, 0, mk(1,1,0,0,0,0,2,0,2));
    // branch beats load-use
    step(1, 8, 2, 0, 0, 1, 8, 1, mk(1,1,1,1,0,0,2,0,2));
    step(1, 1, 2, 0, 0, 0, 0, 0, mk(1,1,0,0,0,0,2,1,2));
    // mult/div: advance then 3 holds, branch/load ignored
    step(1, 1, 2, 0, 1, 0, 0, 0, mk(1,1,0,0,0,0,2,1,2));
    step(1, 1, 2, 0, 0, 0, 0, 0, mk(0,0,0,0,1,1,2,1,2));
    step(1, 1, 2, 0, 1, 0, 0, 1, mk(0,0,0,0,1,1,3,1,3));
    step(1, 8, 2, 0, 0, 1, 8, 0, mk(0,0,0,0,1,1,4,1,3));
    step(1, 1, 2, 0, 0, 0, 0, 0, mk(1,1,0,0,0,0,5,1,3));
    // reset in the 2nd wait cycle abandons the wait
    step(1, 1, 2, 0, 1, 0, 0, 0, mk(1,1,0,0,0,0,5,1,3));
    step(1, 1, 2, 0, 0, 0, 0, 0, mk(0,0,0,0,1,1,5,1,3));
    step(0, 1, 2, 0, 0, 0, 0, 0, mk(0,0,1,1,0,1,6,1,3));
    step(1, 1, 2, 0, 0, 0, 0, 0, mk(1,1,0,0,0,0,0,0,0));
    // five back-to-back stalls saturate the 2-bit counter
    step(1, 8, 2, 0, 0, 1, 8, 0, mk(0,0,0,1,0,0,0,0,0));
    step(1, 8, 2, 0, 0, 1, 8, 0, mk(0,0,0,1,0,0,1,0,1));
    step(1, 8, 2, 0, 0, 1, 8, 0, mk(0,0,0,1,0,0,2,0,2));
    step(1, 8, 2, 0, 0, 1, 8, 0, mk(0,0,0,1,0,0,3,0,3));
    step(1, 8, 2, 0, 0, 1, 8, 0, mk(0,0,0,1,0,0,4,0,3));
    step(1, 1, 2, 0, 0, 0, 0, 0, mk(1,1,0,0,0,0,5,0,3));
    // branch beats mult/div: no wait entered
    step(1, 1, 2, 0, 1, 0, 0, 1, mk(1,1,1,1,0,0,5,0,3));
    step(1, 1, 2, 0, 0, 0, 0, 0, mk(1,1,0,0,0,0,5,1,3));
    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0",
        q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule
